// File: rtl/keypad_if.sv
// Keypad matrix bundle: row sense, column drive and the decoded key report.
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_value;
    logic       key_flag;

    modport master (output row, input  col, input  key_value, input  key_flag);
    modport slave  (input  row, output col, output key_value, output key_flag);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces
// the synchronised rows and reports one key as a held code plus a level flag.
module keypad_scan #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 20
) (
    input  logic    clk,
    input  logic    reset,
    keypad_if.slave kp
);
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div_cnt;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       row_lat;
    logic [1:0]       col_idx;
    logic [3:0]       col_q;
    logic [3:0]       key_value_q;
    logic             key_flag_q;

    logic             tick_c;
    logic             sample_active_c;
    logic [1:0]       sample_row_c;
    logic [1:0]       col_next_c;
    logic [3:0]       col_drive_c;
    logic [CNT_W-1:0] cnt_inc_c;

    assign kp.col       = col_q;
    assign kp.key_value = key_value_q;
    assign kp.key_flag  = key_flag_q;

    // Two-stage synchroniser for the asynchronous row pins; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= kp.row;
            row_sync <= row_meta;
        end
    end

    // Scan divider: one tick per column dwell period.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick_c          = (div_cnt == DIV_MAX);
    assign sample_active_c = ~&row_sync;
    assign col_next_c      = col_idx + 2'd1;
    assign col_drive_c     = ~(4'b0001 << col_next_c);
    assign cnt_inc_c       = cnt + CNT_W'(1);

    // Lowest-numbered low row wins when several rows are active.
    always_comb begin
        sample_row_c = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_sync[i]) begin
                sample_row_c = 2'(i);
            end
        end
    end

    // Scan / debounce state machine; column and key report are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SCAN;
            cnt         <= '0;
            row_lat     <= 2'd0;
            col_idx     <= 2'd0;
            col_q       <= 4'b1110;
            key_value_q <= 4'h0;
            key_flag_q  <= 1'b0;
        end else if (tick_c) begin
            case (state)
                SCAN: begin
                    if (sample_active_c) begin
                        row_lat <= sample_row_c;
                        cnt     <= CNT_W'(1);
                        state   <= DEB_PRESS;
                    end else begin
                        col_idx <= col_next_c;
                        col_q   <= col_drive_c;
                    end
                end
                DEB_PRESS: begin
                    if (sample_active_c && (sample_row_c == row_lat)) begin
                        cnt <= cnt_inc_c;
                        if (cnt_inc_c == CNT_MAX) begin
                            state       <= PRESSED;
                            key_value_q <= ~{row_lat, col_idx};
                            key_flag_q  <= 1'b1;
                        end
                    end else begin
                        state   <= SCAN;
                        col_idx <= col_next_c;
                        col_q   <= col_drive_c;
                    end
                end
                PRESSED: begin
                    if (!sample_active_c) begin
                        cnt   <= CNT_W'(1);
                        state <= DEB_RELEASE;
                    end
                end
                DEB_RELEASE: begin
                    if (!sample_active_c) begin
                        cnt <= cnt_inc_c;
                        if (cnt_inc_c == CNT_MAX) begin
                            state      <= SCAN;
                            key_flag_q <= 1'b0;
                            col_idx    <= col_next_c;
                            col_q      <= col_drive_c;
                        end
                    end else begin
                        state <= PRESSED;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, directed plan cases and random
// key activity checked every cycle against a tick-level behavioural model.
module tb_keypad_scan;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] keys = 16'h0;  // bit r*4+c set = key (r,c) held
    logic [3:0]  row_drv;

    int errors = 0;
    int checks = 0;

    // Reference model state (tick granularity)
    int ph;          // divider phase of the current cycle
    int m_col;       // column being driven
    int m_flag;
    int m_value;
    int press_run;   // consecutive matching press samples
    int cand_row;
    int rel_run;     // consecutive idle samples while held

    keypad_if kp();

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    // Matrix: a row reads low when a held key sits on the driven column.
    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !kp.col[c]) row_drv[r] = 1'b0;
            end
        end
    end
    assign kp.row = row_drv;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = 0; m_col = 0; m_flag = 0; m_value = 0;
        press_run = 0; cand_row = 0; rel_run = 0;
    endtask

    // One scan sample: lowest held row in the driven column, -1 if none.
    task automatic model_tick();
        int r;
        r = -1;
        for (int i = 3; i >= 0; i--) if (keys[i*4+m_col]) r = i;
        if (m_flag == 0) begin
            if (press_run == 0) begin
                if (r >= 0) begin
                    cand_row = r;
                    press_run = 1;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else if (r == cand_row) begin
                press_run++;
                if (press_run == DEB) begin
                    m_flag = 1;
                    m_value = 15 - (4 * r + m_col);
                    press_run = 0;
                    rel_run = 0;
                end
            end else begin
                press_run = 0;
                m_col = (m_col + 1) % 4;
            end
        end else begin
            if (r < 0) begin
                rel_run++;
                if (rel_run == DEB) begin
                    m_flag = 0;
                    rel_run = 0;
                    m_col = (m_col + 1) % 4;
                end
            end else begin
                rel_run = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (ph == SCAN_DIV - 1) model_tick();
        ph = (ph + 1) % SCAN_DIV;
        #1;
        check_eq("col", 32'(kp.col), 32'(15 - (1 << m_col)));
        check_eq("key_flag", 32'(kp.key_flag), 32'(m_flag));
        check_eq("key_value", 32'(kp.key_value), 32'(m_value));
    endtask

    task automatic run_ticks(input int n);
        repeat (n * SCAN_DIV) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_col", 32'(kp.col), 32'h0000000E);
        check_eq("rst_flag", 32'(kp.key_flag), 32'h0);
        check_eq("rst_value", 32'(kp.key_value), 32'h0);
        repeat (n - 1) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic press_release(input int k, input int exp_val, input string tag);
        keys = 16'(1) << k;
        run_ticks(8);
        check_eq({tag, "_flag_on"}, 32'(kp.key_flag), 32'h1);
        check_eq({tag, "_value"}, 32'(kp.key_value), 32'(exp_val));
        keys = 16'h0;
        run_ticks(4);
        check_eq({tag, "_flag_off"}, 32'(kp.key_flag), 32'h0);
        check_eq({tag, "_value_hold"}, 32'(kp.key_value), 32'(exp_val));
    endtask

    initial begin
        model_reset();
        #1;
        do_reset(2);
        check_eq("reset_col", 32'(kp.col), 32'h0000000E);

        // Idle sweep
        run_ticks(1);
        check_eq("sweep_col1", 32'(kp.col), 32'h0000000D);
        run_ticks(3);
        check_eq("sweep_wrap", 32'(kp.col), 32'h0000000E);

        // '1' from column 0: flag after exactly 3 ticks, release after 3
        keys = 16'h0001;
        run_ticks(2);
        check_eq("one_early", 32'(kp.key_flag), 32'h0);
        run_ticks(1);
        check_eq("one_flag", 32'(kp.key_flag), 32'h1);
        check_eq("one_value", 32'(kp.key_value), 32'hF);
        run_ticks(2);
        keys = 16'h0;
        run_ticks(2);
        check_eq("one_rel_early", 32'(kp.key_flag), 32'h1);
        run_ticks(1);
        check_eq("one_rel_flag", 32'(kp.key_flag), 32'h0);
        check_eq("one_rel_value", 32'(kp.key_value), 32'hF);

        press_release(14, 1, "hash");
        press_release(13, 2, "zero");
        press_release(15, 0, "d");

        // Bounce on '5' aligned to its column
        for (int i = 0; i < 4 && m_col != 1; i++) run_ticks(1);
        keys = 16'h0020;
        run_ticks(2);
        keys = 16'h0;
        run_ticks(1);
        check_eq("bounce_flag", 32'(kp.key_flag), 32'h0);
        keys = 16'h0020;
        run_ticks(8);
        check_eq("five_flag", 32'(kp.key_flag), 32'h1);
        check_eq("five_value", 32'(kp.key_value), 32'hA);
        keys = 16'h0;
        run_ticks(4);

        // Release bounce on '8', then reset while held
        keys = 16'h0200;
        run_ticks(8);
        keys = 16'h0;
        run_ticks(2);
        keys = 16'h0200;
        run_ticks(2);
        check_eq("eight_flag", 32'(kp.key_flag), 32'h1);
        check_eq("eight_value", 32'(kp.key_value), 32'h6);
        do_reset(2);
        run_ticks(2);
        keys = 16'h0;
        run_ticks(6);

        // Two keys in column 0, then a third key while pressed
        keys = 16'h0110;
        run_ticks(8);
        check_eq("two_value", 32'(kp.key_value), 32'hB);
        keys = 16'h0111;
        run_ticks(4);
        check_eq("add_flag", 32'(kp.key_flag), 32'h1);
        check_eq("add_value", 32'(kp.key_value), 32'hB);
        keys = 16'h0;
        run_ticks(4);

        // Random key activity, held for whole ticks
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 3))
                0, 1:    keys = 16'h0;
                2:       keys = 16'(1) << $urandom_range(0, 15);
                default: keys = 16'($urandom & $urandom & $urandom);
            endcase
            run_ticks(int'($urandom_range(1, 6)));
            if ($urandom_range(0, 60) == 0) do_reset(int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans the 4x4 matrix keypad, resynchronises and debounces the row inputs, and reports one key at a time as a 4-bit `key_value` with a level `key_flag`. It sits directly upstream of the clock's control block. That block acts on `key_flag` level for some keys and on its falling edge for others, so `key_value` must stay stable through and after release. Key encoding: `key_value = ~{row_idx[1:0], col_idx[1:0]}`. Physical layout:
- row0: 1 2 3 A, giving 15 14 13 12
- row1: 4 5 6 B, giving 11 10 9 8
- row2: 7 8 9 C, giving 7 6 5 4
- row3: * 0 # D, giving 3 2 1 0

## Interface
- `SCAN_DIV`, default 50000: clock cycles per scan tick; this is the column dwell time (1 ms at 50 MHz). Legal values are ≥ 4.
- `DEBOUNCE_CNT`, default 20: number of consecutive matching tick samples needed to confirm a press or a release. Legal values are ≥ 2.
- `clk`, input, 1: system clock. This is the only clock.
- `reset`, input, 1: synchronous, active-high reset.
- `row`, input, 4: keypad rows, active low (externally pulled up), asynchronous to `clk`.
- `col`, output, 4: column drive, active low, exactly one bit low at any time.
- `key_value`, output, 4: encoded key code, registered.
- `key_flag`, output, 1: high while a debounced key is held, registered.

## Operation
- Input synchronisation: `row` passes through a 2-FF synchroniser before any use.
- Tick generation: a divider counts 0..SCAN_DIV-1 and asserts a tick on the cycle where it equals SCAN_DIV-1. Synchronised rows are sampled only on tick cycles.
- Row selection: a sample is "active" if any row bit is 0. If several rows are low, the lowest row index wins.
- State machine: four states, SCAN, DEB_PRESS, PRESSED and DEB_RELEASE, plus a debounce counter `cnt`.
  - SCAN, on tick:
    - If the sample is inactive, advance the column (0→1→2→3→0). `col` changes on the cycle after the tick.
    - If the sample is active, latch the row index and column index, set `cnt=1`, and go to DEB_PRESS. The column is frozen.
  - DEB_PRESS, on tick:
    - If the sample is active with the same row index, increment `cnt`. When `cnt` reaches DEBOUNCE_CNT, go to PRESSED.
    - Otherwise (inactive, or a different row), return to SCAN and advance the column.
  - PRESSED: `col` stays frozen. On tick, an inactive sample sets `cnt=1` and moves to DEB_RELEASE. Changes between active row patterns are ignored, and `key_value` is not updated.
  - DEB_RELEASE, on tick:
    - If the sample is inactive, increment `cnt`. When `cnt` reaches DEBOUNCE_CNT, go to SCAN and advance the column.
    - If the sample is active, return to PRESSED. `key_flag` stays high.
- `key_value` is written only on entry to PRESSED. It holds its value through release and until the next confirmed press.
- Outputs by state: `key_flag` = 1 in PRESSED and DEB_RELEASE, 0 otherwise. `col` = ~(1 << col_idx).

## Timing
- Reset values: `col=4'b1110`, `key_value=4'h0`, `key_flag=0`, state SCAN, divider 0, `cnt` 0, synchroniser FFs all 1.
- Reset is synchronous. An assertion mid-press forces all reset values on the next edge; `key_flag` falls with no release debounce.
- Press latency: `key_flag` rises, with `key_value` valid on the same edge, one cycle after the tick carrying the DEBOUNCE_CNT-th matching sample.
- Release latency: `key_flag` falls one cycle after the tick carrying the DEBOUNCE_CNT-th consecutive inactive sample. `key_value` is unchanged on that edge and afterwards.
- Row changes reach the sampled value 2 cycles after the pin change, because of the synchroniser.
- Minimum cost: a press costs at least DEBOUNCE_CNT ticks; a press plus release costs at least 2·DEBOUNCE_CNT ticks.
- A full idle sweep of the 4 columns takes 4·SCAN_DIV cycles.
- Pulse spacing: `key_flag` never pulses for fewer than DEBOUNCE_CNT·SCAN_DIV cycles. Two rising edges are always separated by a falling edge.

## Test plan
Bench settings: SCAN_DIV=4 and DEBOUNCE_CNT=3. The keypad model drives `row[r]=0` iff key (r,c) is pressed and `col[c]==0`.
- **Reset:** assert `reset` for 2 cycles → `col=1110`, `key_flag=0`, `key_value=0`. With no keys pressed, `col` cycles 1110→1101→1011→0111→1110 every 4 cycles.
- **Clean press of '1' then release:** hold (0,0) → `key_flag` rises with `key_value=15`, about 3 ticks after the scan reaches col0. Release → `key_flag` falls 3 ticks later and `key_value` stays 15.
- **Clean press of '#'** (row3, col2) → `key_value=1`, `key_flag=1`. **'0'** (row3, col1) → `key_value=2`. **'D'** (row3, col3) → `key_value=0`.
- **Bounce:** press '5' for 2 ticks, release for 1 tick, then hold → no flag during the bounce. The flag rises only after 3 consecutive matching ticks, with `key_value=10`.
- **Release bounce and reset:** while '8' is held, release for 2 ticks then re-press → `key_flag` stays 1 and `key_value=6`. Then assert `reset` while the key is held → next edge gives `key_flag=0`, `col=1110`.
- **Two keys in one column:** hold '4' and '7' (rows 1 and 2, col0) → `key_value=11`. Adding a second key while in PRESSED does not change `key_value`.
